// File: rtl/adc_byte_packer.sv
// Buffers 24-bit ADC sample frames in a FIFO and serialises each one into bytes, MSB first,
// with an optional sync header, over a valid/ready byte handshake. Dropped samples are counted.
module adc_byte_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          HEADER_EN  = 1'b1,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [23:0]                   i_data_frame,
  input  logic                          i_data_ready,
  output logic [7:0]                    o_byte,
  output logic                          o_byte_valid,
  input  logic                          i_byte_ready,
  output logic                          o_overflow,
  input  logic                          i_clear_overflow,
  output logic [15:0]                   o_drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StHdr, StB2, StB1, StB0} state_e;

  logic [23:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;

  state_e          state_q;
  logic [23:0]     word_q;
  logic [7:0]      byte_q;
  logic            valid_q;

  logic            full, push, drop, hs, pop;
  logic [23:0]     head;
  logic [7:0]      first_byte;
  state_e          first_state;

  // Fullness is judged on the pre-edge level, so a same-edge pop never rescues a sample.
  always_comb begin
    full        = (level_q == LvlFull);
    push        = i_data_ready && !full;
    drop        = i_data_ready && full;
    hs          = valid_q && i_byte_ready;
    pop         = (level_q != '0) &&
                  ((state_q == StIdle) || ((state_q == StB0) && hs));
    head        = mem_q[rd_ptr_q];
    first_byte  = HEADER_EN ? SYNC_BYTE : head[23:16];
    first_state = HEADER_EN ? StHdr : StB2;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      if (i_clear_overflow) begin
        drop_d = 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (i_clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data_frame;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      word_q  <= 24'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            word_q  <= head;
            byte_q  <= first_byte;
            valid_q <= 1'b1;
            state_q <= first_state;
          end
        end
        StHdr: begin
          if (hs) begin
            byte_q  <= word_q[23:16];
            state_q <= StB2;
          end
        end
        StB2: begin
          if (hs) begin
            byte_q  <= word_q[15:8];
            state_q <= StB1;
          end
        end
        StB1: begin
          if (hs) begin
            byte_q  <= word_q[7:0];
            state_q <= StB0;
          end
        end
        StB0: begin
          if (hs) begin
            // Chain straight into the next queued word so the byte stream has no bubble.
            if (pop) begin
              word_q  <= head;
              byte_q  <= first_byte;
              state_q <= first_state;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_overflow   = ovf_q;
  assign o_drop_count = drop_q;
  assign o_fifo_level = level_q;

endmodule
